acc_req_buffer: RTL and testbench

- Commit-gated request buffer between the CVA6 issue stage and the vector accelerator (RVV enabled, XLEN=64, 8 scoreboard entries).
- Holds speculative accelerator instructions and their operands until commit. Committed requests are then issued in order over a valid/ready port.
- Tracks outstanding accelerator operations and returns results to scoreboard writeback, registered.
- Flush discards every entry not yet committed.

---
 rtl/acc_req_buffer_pkg.sv | 23 ++
 rtl/acc_req_buffer_if.sv | 49 ++++
 rtl/acc_req_buffer.sv | 106 ++++++++++
 tb/tb_acc_req_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_req_buffer_pkg.sv
// rtl/acc_req_buffer_pkg.sv - shared types and widths for the accelerator request buffer
package acc_req_buffer_pkg;

    localparam int XLEN                = 64;
    localparam int NrScoreboardEntries = 8;
    localparam int TransIdWidth        = $clog2(NrScoreboardEntries);

    typedef logic [TransIdWidth-1:0] trans_id_t;

    typedef struct packed {
        logic [31:0]     insn;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        trans_id_t       trans_id;
    } acc_req_t;

    typedef struct packed {
        trans_id_t       trans_id;
        logic [XLEN-1:0] result;
        logic            error;
    } acc_resp_t;

endpackage

// File: rtl/acc_req_buffer_if.sv
// rtl/acc_req_buffer_if.sv - issue, accelerator and writeback channels of the request buffer
interface acc_req_buffer_if;
    import acc_req_buffer_pkg::*;

    logic                req_valid_i;
    logic                req_ready_o;
    logic [31:0]         req_insn_i;
    logic [XLEN-1:0]     req_rs1_i;
    logic [XLEN-1:0]     req_rs2_i;
    trans_id_t           req_trans_id_i;

    logic                acc_req_valid_o;
    logic                acc_req_ready_i;
    logic [31:0]         acc_req_insn_o;
    logic [XLEN-1:0]     acc_req_rs1_o;
    logic [XLEN-1:0]     acc_req_rs2_o;
    trans_id_t           acc_req_trans_id_o;

    logic                acc_resp_valid_i;
    trans_id_t           acc_resp_trans_id_i;
    logic [XLEN-1:0]     acc_resp_result_i;
    logic                acc_resp_error_i;

    logic                wb_valid_o;
    trans_id_t           wb_trans_id_o;
    logic [XLEN-1:0]     wb_result_o;
    logic                wb_exception_o;

    // Buffer side
    modport slave (
        input  req_valid_i, req_insn_i, req_rs1_i, req_rs2_i, req_trans_id_i,
        output req_ready_o,
        output acc_req_valid_o, acc_req_insn_o, acc_req_rs1_o, acc_req_rs2_o, acc_req_trans_id_o,
        input  acc_req_ready_i,
        input  acc_resp_valid_i, acc_resp_trans_id_i, acc_resp_result_i, acc_resp_error_i,
        output wb_valid_o, wb_trans_id_o, wb_result_o, wb_exception_o
    );

    // Issue stage / accelerator / scoreboard side
    modport master (
        output req_valid_i, req_insn_i, req_rs1_i, req_rs2_i, req_trans_id_i,
        input  req_ready_o,
        input  acc_req_valid_o, acc_req_insn_o, acc_req_rs1_o, acc_req_rs2_o, acc_req_trans_id_o,
        output acc_req_ready_i,
        output acc_resp_valid_i, acc_resp_trans_id_i, acc_resp_result_i, acc_resp_error_i,
        input  wb_valid_o, wb_trans_id_o, wb_result_o, wb_exception_o
    );

endinterface

// File: rtl/acc_req_buffer.sv
// rtl/acc_req_buffer.sv - commit-gated request buffer between issue stage and vector accelerator
module acc_req_buffer
    import acc_req_buffer_pkg::*;
#(
    parameter int Depth          = 8,
    parameter int MaxOutstanding = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             commit_i,
    output logic             idle_o,
    acc_req_buffer_if.slave  bus
);

    localparam int IdxW = $clog2(Depth);
    localparam int PtrW = IdxW + 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    acc_req_t mem_q [Depth];
    acc_req_t mem_d [Depth];
    ptr_t     wr_ptr_q, wr_ptr_d;
    ptr_t     cmt_ptr_q, cmt_ptr_d;
    ptr_t     iss_ptr_q, iss_ptr_d;
    cnt_t     outs_q, outs_d;
    logic     wb_valid_q, wb_valid_d;
    acc_resp_t wb_q, wb_d;

    logic full, req_ready, enq, do_commit, acc_valid, issue;

    always_comb begin
        mem_d      = mem_q;
        full       = (wr_ptr_q - iss_ptr_q) == ptr_t'(Depth);
        req_ready  = !full && !flush_i;
        enq        = bus.req_valid_i && req_ready;
        do_commit  = commit_i && (cmt_ptr_q != wr_ptr_q);
        acc_valid  = (iss_ptr_q != cmt_ptr_q) && (outs_q < cnt_t'(MaxOutstanding));
        issue      = acc_valid && bus.acc_req_ready_i;

        if (enq) begin
            mem_d[wr_ptr_q[IdxW-1:0]] = '{insn:     bus.req_insn_i,
                                          rs1:      bus.req_rs1_i,
                                          rs2:      bus.req_rs2_i,
                                          trans_id: bus.req_trans_id_i};
        end

        // Commit is resolved before flush so a same-cycle commit survives the rollback.
        cmt_ptr_d = cmt_ptr_q + ptr_t'(do_commit);
        wr_ptr_d  = flush_i ? cmt_ptr_d : wr_ptr_q + ptr_t'(enq);
        iss_ptr_d = iss_ptr_q + ptr_t'(issue);

        outs_d = outs_q;
        if (issue && !bus.acc_resp_valid_i) begin
            outs_d = outs_q + cnt_t'(1);
        end else if (!issue && bus.acc_resp_valid_i && outs_q != '0) begin
            outs_d = outs_q - cnt_t'(1);
        end

        wb_valid_d = bus.acc_resp_valid_i;
        wb_d       = '{trans_id: bus.acc_resp_trans_id_i,
                       result:   bus.acc_resp_result_i,
                       error:    bus.acc_resp_error_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            iss_ptr_q  <= '0;
            outs_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            iss_ptr_q  <= iss_ptr_d;
            outs_q     <= outs_d;
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
        end
    end

    assign bus.req_ready_o        = req_ready;
    assign bus.acc_req_valid_o    = acc_valid;
    assign bus.acc_req_insn_o     = mem_q[iss_ptr_q[IdxW-1:0]].insn;
    assign bus.acc_req_rs1_o      = mem_q[iss_ptr_q[IdxW-1:0]].rs1;
    assign bus.acc_req_rs2_o      = mem_q[iss_ptr_q[IdxW-1:0]].rs2;
    assign bus.acc_req_trans_id_o = mem_q[iss_ptr_q[IdxW-1:0]].trans_id;
    assign bus.wb_valid_o         = wb_valid_q;
    assign bus.wb_trans_id_o      = wb_q.trans_id;
    assign bus.wb_result_o        = wb_q.result;
    assign bus.wb_exception_o     = wb_q.error;
    assign idle_o                 = (wr_ptr_q == iss_ptr_q) && (outs_q == '0);

    commit_has_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_i |-> (cmt_ptr_q != wr_ptr_q));

    resp_has_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.acc_resp_valid_i |-> (outs_q != '0));

endmodule

// File: tb/tb_acc_req_buffer.sv
// tb/tb_acc_req_buffer.sv - directed self-checking bench for acc_req_buffer
module tb_acc_req_buffer;
    import acc_req_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_ni, flush_i, commit_i, idle_o;
    int   tests = 0;
    int   fails = 0;

    acc_req_buffer_if bus ();

    acc_req_buffer #(.Depth(8), .MaxOutstanding(7)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .commit_i (commit_i),
        .idle_o   (idle_o),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] id, input logic [31:0] insn);
        bus.req_valid_i    = 1'b1;
        bus.req_insn_i     = insn;
        bus.req_rs1_i      = 64'h100 + 64'(id);
        bus.req_rs2_i      = 64'h200 + 64'(id);
        bus.req_trans_id_i = id;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; commit_i = 1'b0;
        bus.req_valid_i = 1'b0; bus.req_insn_i = '0; bus.req_rs1_i = '0;
        bus.req_rs2_i = '0; bus.req_trans_id_i = '0;
        bus.acc_req_ready_i = 1'b0;
        bus.acc_resp_valid_i = 1'b0; bus.acc_resp_trans_id_i = '0;
        bus.acc_resp_result_i = '0; bus.acc_resp_error_i = 1'b0;
        tick; tick;
        rst_ni = 1'b1;
        settle;
        chk("rst_req_ready", bus.req_ready_o, 1);
        chk("rst_acc_valid", bus.acc_req_valid_o, 0);
        chk("rst_wb_valid", bus.wb_valid_o, 0);
        chk("rst_wb_exc", bus.wb_exception_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_acc_insn", bus.acc_req_insn_o, 0);
        chk("rst_wb_result", bus.wb_result_o, 0);

        // Three uncommitted requests never reach the accelerator
        for (int k = 1; k <= 3; k++) begin
            set_req(3'(k), 32'hA000_0000 + 32'(k));
            tick;
        end
        bus.req_valid_i = 1'b0;
        settle;
        chk("uncommitted_valid", bus.acc_req_valid_o, 0);
        chk("uncommitted_idle", idle_o, 0);
        tick;
        chk("uncommitted_valid2", bus.acc_req_valid_o, 0);

        // Two commits: ids 1 and 2 issue on consecutive cycles
        bus.acc_req_ready_i = 1'b1;
        commit_i = 1'b1;
        settle;
        chk("commit_cycle_valid", bus.acc_req_valid_o, 0);
        tick;
        settle;
        chk("issue1_valid", bus.acc_req_valid_o, 1);
        chk("issue1_id", bus.acc_req_trans_id_o, 1);
        chk("issue1_insn", bus.acc_req_insn_o, 32'hA000_0001);
        chk("issue1_rs1", bus.acc_req_rs1_o, 64'h101);
        tick;
        commit_i = 1'b0;
        settle;
        chk("issue2_valid", bus.acc_req_valid_o, 1);
        chk("issue2_id", bus.acc_req_trans_id_o, 2);
        chk("issue2_rs2", bus.acc_req_rs2_o, 64'h202);
        tick;
        settle;
        chk("id3_held", bus.acc_req_valid_o, 0);

        // Ids 4,5 enqueued, then flush with commit keeps id 3 only
        for (int k = 4; k <= 5; k++) begin
            set_req(3'(k), 32'hA000_0000 + 32'(k));
            tick;
        end
        bus.req_valid_i = 1'b0;
        flush_i = 1'b1;
        commit_i = 1'b1;
        settle;
        chk("flush_req_ready", bus.req_ready_o, 0);
        tick;
        flush_i = 1'b0;
        commit_i = 1'b0;
        settle;
        chk("flush_kept_valid", bus.acc_req_valid_o, 1);
        chk("flush_kept_id", bus.acc_req_trans_id_o, 3);
        tick;
        settle;
        chk("flush_dropped", bus.acc_req_valid_o, 0);

        // Drain ids 1..3; idle afterwards proves 4,5 were discarded
        for (int k = 1; k <= 3; k++) begin
            bus.acc_resp_valid_i    = 1'b1;
            bus.acc_resp_trans_id_i = 3'(k);
            bus.acc_resp_result_i   = 64'h10 * 64'(k);
            bus.acc_resp_error_i    = 1'b0;
            tick;
            settle;
            chk("wb_valid", bus.wb_valid_o, 1);
            chk("wb_id", bus.wb_trans_id_o, 64'(k));
            chk("wb_result", bus.wb_result_o, 64'h10 * 64'(k));
            chk("wb_exc", bus.wb_exception_o, 0);
        end
        bus.acc_resp_valid_i = 1'b0;
        settle;
        chk("drained_idle", idle_o, 1);
        tick;
        settle;
        chk("wb_valid_drop", bus.wb_valid_o, 0);

        // Fill all 8 entries across the index wrap with the accelerator stalled
        bus.acc_req_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_req(3'(k), 32'hB000_0000 + 32'(k));
            settle;
            chk("fill_ready", bus.req_ready_o, 1);
            tick;
        end
        bus.req_valid_i = 1'b0;
        settle;
        chk("full_ready", bus.req_ready_o, 0);

        commit_i = 1'b1;
        for (int k = 0; k < 8; k++) tick;
        commit_i = 1'b0;
        settle;
        chk("stall_valid", bus.acc_req_valid_o, 1);
        chk("stall_id", bus.acc_req_trans_id_o, 0);
        chk("stall_insn", bus.acc_req_insn_o, 32'hB000_0000);

        // Seven issue, the eighth is held by the outstanding limit
        bus.acc_req_ready_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            settle;
            chk("wrap_valid", bus.acc_req_valid_o, 1);
            chk("wrap_id", bus.acc_req_trans_id_o, 64'(k));
            chk("wrap_insn", bus.acc_req_insn_o, 32'hB000_0000 + 32'(k));
            tick;
        end
        settle;
        chk("max_outs_held", bus.acc_req_valid_o, 0);
        chk("max_outs_ready", bus.req_ready_o, 1);

        bus.acc_resp_valid_i    = 1'b1;
        bus.acc_resp_trans_id_i = 3'd2;
        bus.acc_resp_result_i   = 64'hDEAD;
        bus.acc_resp_error_i    = 1'b1;
        tick;
        bus.acc_resp_valid_i    = 1'b0;
        bus.acc_resp_error_i    = 1'b0;
        settle;
        chk("err_wb_valid", bus.wb_valid_o, 1);
        chk("err_wb_id", bus.wb_trans_id_o, 2);
        chk("err_wb_result", bus.wb_result_o, 64'hDEAD);
        chk("err_wb_exc", bus.wb_exception_o, 1);
        chk("eighth_valid", bus.acc_req_valid_o, 1);
        chk("eighth_id", bus.acc_req_trans_id_o, 7);
        chk("eighth_insn", bus.acc_req_insn_o, 32'hB000_0007);
        tick;
        settle;
        chk("eighth_issued", bus.acc_req_valid_o, 0);
        chk("wb_valid_clear", bus.wb_valid_o, 0);

        // Bring outstanding down to 2, buffer 4 entries, then reset
        for (int k = 0; k < 5; k++) begin
            bus.acc_resp_valid_i    = 1'b1;
            bus.acc_resp_trans_id_i = 3'(k);
            bus.acc_resp_result_i   = 64'(k);
            tick;
        end
        bus.acc_resp_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(3'(k), 32'hC000_0000 + 32'(k));
            tick;
        end
        bus.req_valid_i = 1'b0;
        settle;
        chk("pre_reset_idle", idle_o, 0);
        rst_ni = 1'b0;
        tick;
        rst_ni = 1'b1;
        settle;
        chk("post_reset_idle", idle_o, 1);
        chk("post_reset_valid", bus.acc_req_valid_o, 0);
        chk("post_reset_ready", bus.req_ready_o, 1);
        chk("post_reset_wb", bus.wb_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
